// File: rtl/ild_pkg.sv
// Shared widths and FSM state type for the iterative-logarithmic divider.
package ild_pkg;

  localparam int N     = 16;          // operand width
  localparam int FRAC  = 16;          // quotient fraction bits
  localparam int QW    = N + FRAC;    // quotient width (Q16.16)
  localparam int XW    = QW + N;      // core numerator width (48)
  localparam int RW    = XW + 1;      // signed residual width (49)
  localparam int XLW   = 6;           // LOD index width for the 48b numerator
  localparam int BLW   = 4;           // LOD index width for the 16b divisor
  localparam int CNT_W = 3;           // correction counter width (ITER up to 7)

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EST  = 3'd1,
    RES  = 3'd2,
    CORR = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mitchell_div_core.sv
// Combinational Mitchell log-difference divider: 48b numerator / 16b divisor
// -> 32b quotient (numerator scaled so the result is Q16.16), saturating.
module mitchell_div_core
  import ild_pkg::*;
(
  input  logic [XW-1:0] num_i,
  input  logic [N-1:0]  div_i,
  output logic [QW-1:0] quo_o
);

  logic [XLW-1:0]    kx_s;
  logic [BLW-1:0]    kb_s;
  logic [XW-1:0]     xn_s;
  logic [N-1:0]      bn_s;
  logic [14:0]       fx_s;
  logic [14:0]       fb_s;
  logic signed [7:0] e_s;
  logic signed [7:0] exp_s;
  logic signed [7:0] sh_s;
  logic [7:0]        shamt_s;
  logic [16:0]       m_s;
  logic [49:0]       wide_s;

  // Leading-one detect, fraction difference, antilog shift and saturation.
  always_comb begin
    kx_s = '0;
    for (int i = 0; i < XW; i++) begin
      if (num_i[i]) kx_s = XLW'(i);
    end
    kb_s = '0;
    for (int j = 0; j < N; j++) begin
      if (div_i[j]) kb_s = BLW'(j);
    end
    // Normalise so the leading one sits at the top; the 15 bits below it are the fraction.
    xn_s = num_i << (6'd47 - kx_s);
    bn_s = div_i << (4'd15 - kb_s);
    fx_s = xn_s[46:32];
    fb_s = bn_s[14:0];
    e_s  = $signed({2'b00, kx_s}) - $signed({4'b0000, kb_s});
    if (fx_s >= fb_s) begin
      m_s   = {2'b01, fx_s - fb_s};
      exp_s = e_s;
    end else begin
      // Negative fraction difference borrows one from the exponent.
      m_s   = 17'h1_0000 + {2'b00, fx_s} - {2'b00, fb_s};
      exp_s = e_s - 8'sd1;
    end
    sh_s = exp_s - 8'sd15;
    if (!sh_s[7]) begin
      shamt_s = sh_s;
      wide_s  = {33'd0, m_s} << shamt_s;
    end else begin
      shamt_s = 8'd0 - sh_s;
      wide_s  = {33'd0, m_s} >> shamt_s;
    end
    if (num_i == {XW{1'b0}}) begin
      quo_o = {QW{1'b0}};
    end else if (|wide_s[49:32]) begin
      quo_o = {QW{1'b1}};
    end else begin
      quo_o = wide_s[31:0];
    end
  end

endmodule

// File: rtl/ild_div_seq.sv
// Sequential iterative-logarithmic approximate divider, 16b/16b -> Q16.16.
// A Mitchell estimate is refined by up to ITER residual-driven corrections
// that reuse the same log core. Optional macro ILD_DIV_SAT_EN makes a zero
// divisor return 32'hFFFF_FFFF instead of 0 (div_by_zero is set either way).
module ild_div_seq
  import ild_pkg::*;
#(
  parameter int ITER = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  dividend,
  input  logic [N-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic          div_by_zero
);

  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);
`ifdef ILD_DIV_SAT_EN
  localparam logic [QW-1:0] DBZ_QUOT = {QW{1'b1}};
`else
  localparam logic [QW-1:0] DBZ_QUOT = {QW{1'b0}};
`endif

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [QW-1:0]    q_q, q_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QW-1:0]    quotient_q, quotient_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;

  logic [XW-1:0]    core_num_s;
  logic [QW-1:0]    core_q_s;
  logic [XW-1:0]    r_abs_s;
  logic [XW-1:0]    prod_s;
  logic [RW-1:0]    resid_s;
  logic [QW:0]      sum_s;
  logic [QW:0]      diff_s;
  logic [QW-1:0]    clamp_s;

  // The single log core: estimate from a<<16 in EST, correction from |R| in CORR.
  assign core_num_s = (state_q == CORR) ? r_abs_s : {a_q, {FRAC{1'b0}}};

  mitchell_div_core u_core (
    .num_i (core_num_s),
    .div_i (b_q),
    .quo_o (core_q_s)
  );

  // Residual R = (a<<16) - q*b and the clamped correction step.
  always_comb begin
    prod_s  = {{N{1'b0}}, q_q} * {{QW{1'b0}}, b_q};
    resid_s = {17'd0, a_q, {FRAC{1'b0}}} - {1'b0, prod_s};
    // |R| always fits 48 bits because q*b < 2^48.
    r_abs_s = r_q[RW-1] ? (~r_q[XW-1:0] + 48'd1) : r_q[XW-1:0];
    sum_s   = {1'b0, q_q} + {1'b0, core_q_s};
    diff_s  = {1'b0, q_q} - {1'b0, core_q_s};
    if (r_q[RW-1]) begin
      clamp_s = diff_s[QW] ? {QW{1'b0}} : diff_s[QW-1:0];
    end else begin
      clamp_s = sum_s[QW] ? {QW{1'b1}} : sum_s[QW-1:0];
    end
  end

  // Next-state and datapath register updates for the divider FSM.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    q_d        = q_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    quotient_d = quotient_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = dividend;
          b_d     = divisor;
          cnt_d   = {CNT_W{1'b0}};
          state_d = EST;
        end else begin
          state_d = IDLE;
        end
      end
      EST: begin
        q_d = core_q_s;
        if ((a_q == {N{1'b0}}) || (b_q == {N{1'b0}})) begin
          quotient_d = (b_q == {N{1'b0}}) ? DBZ_QUOT : {QW{1'b0}};
          dbz_d      = (b_q == {N{1'b0}});
          state_d    = DONE;
        end else begin
          state_d = RES;
        end
      end
      RES: begin
        r_d = resid_s;
        if ((resid_s == {RW{1'b0}}) || (cnt_q == ITER_C)) begin
          quotient_d = q_q;
          dbz_d      = 1'b0;
          state_d    = DONE;
        end else begin
          state_d = CORR;
        end
      end
      CORR: begin
        q_d     = clamp_s;
        cnt_d   = cnt_q + 3'd1;
        state_d = RES;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; async reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      q_q         <= {QW{1'b0}};
      r_q         <= {RW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      quotient_q  <= {QW{1'b0}};
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      q_q         <= q_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ild_div_seq.sv
// Self-checking bench for ild_div_seq: directed vector table, multi-cycle
// hold/reset sequences, and random operands against an arithmetic model.
module tb_ild_div_seq;

  localparam int ITER = 2;
`ifdef ILD_DIV_SAT_EN
  localparam logic [31:0] DBZ_Q = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] DBZ_Q = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = 16'd0;
  logic [15:0] divisor = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ild_div_seq #(.ITER(ITER)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mitchell log-difference quotient computed with plain integer arithmetic.
  function automatic longint core_m(input longint x, input longint b);
    longint kx, kb, fx, fb, m, e, sh, r;
    if (x == 0) return 0;
    kx = 0;
    while ((x >> (kx + 1)) != 0) kx++;
    kb = 0;
    while ((b >> (kb + 1)) != 0) kb++;
    fx = ((x - (longint'(1) << kx)) << 15) >> kx;
    fb = ((b - (longint'(1) << kb)) << 15) >> kb;
    if (fx >= fb) begin
      m = 32768 + fx - fb;
      e = kx - kb;
    end else begin
      m = 65536 + fx - fb;
      e = kx - kb - 1;
    end
    sh = e - 15;
    r = (sh >= 0) ? (m << sh) : (m >> (-sh));
    if (r > 64'sh0_FFFF_FFFF) r = 64'sh0_FFFF_FFFF;
    return r;
  endfunction

  // Whole-division reference: estimate, then residual corrections, plus latency.
  task automatic model_div(input longint a, input longint b,
                           output longint q, output logic dbz, output int lat);
    longint x, r, d;
    int cnt;
    if (a == 0 || b == 0) begin
      q   = (b == 0) ? longint'(DBZ_Q) : 0;
      dbz = (b == 0);
      lat = 2;
      return;
    end
    dbz = 1'b0;
    x   = a * 65536;
    q   = core_m(x, b);
    lat = 3;
    cnt = 0;
    forever begin
      r = x - q * b;
      if (r == 0 || cnt == ITER) break;
      d = core_m((r < 0) ? -r : r, b);
      q = (r > 0) ? q + d : q - d;
      if (q < 0) q = 0;
      if (q > 64'sh0_FFFF_FFFF) q = 64'sh0_FFFF_FFFF;
      cnt++;
      lat += 2;
    end
  endtask

  // One transaction: accept, count edges to out_valid, optionally stall, consume.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [31:0] q, output logic dbz, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    q   = quotient;
    dbz = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid_ready", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic        dbz;
    int          lat;
  } vec_t;

  initial begin
    vec_t        vecs[7];
    logic [31:0] q;
    logic        dbz;
    int          lat;
    longint      mq;
    logic        mdbz;
    int          mlat;
    logic [15:0] ra, rb;

    vecs[0] = '{16'd100,    16'd10,     32'h000A_0000, 1'b0, 5};
    vecs[1] = '{16'h8000,   16'h0002,   32'h4000_0000, 1'b0, 3};
    vecs[2] = '{16'd7,      16'd0,      DBZ_Q,         1'b1, 2};
    vecs[3] = '{16'd0,      16'd5,      32'h0000_0000, 1'b0, 2};
    vecs[4] = '{16'hFFFF,   16'h0001,   32'hFFFF_0000, 1'b0, 3};
    vecs[5] = '{16'd0,      16'd0,      DBZ_Q,         1'b1, 2};
    vecs[6] = '{16'd1,      16'd1,      32'h0001_0000, 1'b0, 3};

    // Reset state.
    #12;
    check("reset_in_ready",  {63'd0, in_ready},    64'd1);
    check("reset_out_valid", {63'd0, out_valid},   64'd0);
    check("reset_quotient",  {32'd0, quotient},    64'd0);
    check("reset_dbz",       {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, i % 3, q, dbz, lat);
      check($sformatf("vec%0d_quotient", i), {32'd0, q},   {32'd0, vecs[i].q});
      check($sformatf("vec%0d_dbz", i),      {63'd0, dbz}, {63'd0, vecs[i].dbz});
      check($sformatf("vec%0d_latency", i),  64'(lat),     64'(vecs[i].lat));
    end

    // Stall with out_ready low and in_valid high: outputs hold, nothing new accepted.
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd10;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 16'd5;
    divisor  = 16'd1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("hold_latency", 64'(lat), 64'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d_state", i), {32'd0, quotient[31:0]}, 64'h000A_0000);
      check($sformatf("hold%0d_flags", i), {61'd0, out_valid, in_ready, div_by_zero}, 64'b100);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("hold_no_new_accept", {62'd0, out_valid, in_ready}, 64'b01);

    // Asynchronous reset while the divider sits in RES.
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd10;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready",  {63'd0, in_ready},    64'd1);
    check("midreset_out_valid", {63'd0, out_valid},   64'd0);
    check("midreset_quotient",  {32'd0, quotient},    64'd0);
    check("midreset_dbz",       {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd100, 16'd10, 0, q, dbz, lat);
    check("after_reset_quotient", {32'd0, q}, 64'h000A_0000);
    check("after_reset_latency",  64'(lat),   64'd5);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       rb = 16'd0;
        1, 2, 3: rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      ra = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
      model_div(longint'(ra), longint'(rb), mq, mdbz, mlat);
      run_op(ra, rb, $urandom_range(0, 3), q, dbz, lat);
      check($sformatf("rand%0d_q a=%0h b=%0h", i, ra, rb), {32'd0, q}, 64'(mq));
      check($sformatf("rand%0d_dbz", i), {63'd0, dbz}, {63'd0, mdbz});
      check($sformatf("rand%0d_lat", i), 64'(lat), 64'(mlat));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
